seg7_scan_decoder: RTL and testbench
====================================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive clocks an anode/segment pair must hold before capture (legal range 1..255).
REQ-002 Port clk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous, active-low.
REQ-004 Port Anode_Activate, input, 8: scanned digit enables, active-low; bit i low selects digit i.
REQ-005 Port LED_out, input, 7: segment pattern, active-low; bit6=a, bit5=b, ..., bit0=g.
REQ-006 Port clear_err, input, 1: synchronous clear of the sticky error flags.
REQ-007 Port digits, output, 32: recovered hex value of digit i in bits [4i+3:4i].
REQ-008 Port digit_valid, output, 8: bit i set once digit i has been captured in the current frame.
REQ-009 Port frame_done, output, 1: one-cycle pulse when all 8 digits have been captured.
REQ-010 Port pattern_err, output, 1: sticky; a stable pattern matched no hex glyph.
REQ-011 Port anode_err, output, 1: sticky; a stable anode vector had more than one bit low.

Function
REQ-012 Inputs SHALL be registered once into a sample register before any comparison.
REQ-013 State machine SHALL have states IDLE, SETTLE and HELD.
REQ-014 IDLE: sample anode all-ones (blank) -> remain in IDLE; any other sample -> SETTLE with stable count = 1.
REQ-015 SETTLE: sample equal to the previous sample -> count increments; a differing sample -> count restarts at 1, or IDLE if the sample is blank.
REQ-016 When the count reaches STABLE_CYCLES, the block SHALL evaluate the pair on that edge and enter HELD.
REQ-017 Latency: a pair applied continuously from before rising edge k SHALL update the outputs at edge k+STABLE_CYCLES.
REQ-018 Evaluation, exactly one anode bit low and a legal glyph -> digits nibble i written and digit_valid[i] set.
REQ-019 Evaluation, more than one anode bit low -> anode_err set; no digit written.
REQ-020 Evaluation, one anode bit low and an unknown glyph -> pattern_err set; no digit written.
REQ-021 HELD: no re-capture while the sample is unchanged; a changed sample -> SETTLE with count 1, or IDLE if blank.
REQ-022 Glyph table, active-low with bit6=a to bit0=g:
  0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111
  8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
REQ-023 Re-capturing a digit that is already valid SHALL overwrite its nibble and leave the mask unchanged.
REQ-024 When a capture would complete the mask (all 8 bits set), on that edge frame_done SHALL be set for one cycle and digit_valid cleared to 0; digits are retained.
REQ-025 frame_done SHALL deassert on the following edge.
REQ-026 clear_err SHALL clear both sticky flags; if an error occurs on the same edge, the error SHALL win.
REQ-027 The stable counter SHALL saturate and never wrap.

Reset
REQ-028 rst low SHALL asynchronously force state IDLE, count 0, sample register to all-ones, digits=0, digit_valid=0, frame_done=0, pattern_err=0, anode_err=0.
REQ-029 Reset asserted mid-SETTLE SHALL discard the partial count, with no capture after release until a fresh STABLE_CYCLES window completes.

Structure
REQ-030 Shared package seg7_pkg SHALL hold the state enum, the 16-entry glyph constant table and the blank-anode constant (8'hFF).
REQ-031 Sub-module seg7_glyph_decode (combinational) SHALL map a 7-bit pattern to a 4-bit value plus a hit flag.

Verification
REQ-032 Anode 8'b11111110 with pattern 0000110 held for 4 clocks -> digits[3:0]=3 and digit_valid=8'h01 at edge k+4; no change at edge k+3.
REQ-033 Scan digits 0..7 with values 1,2,...,8, each held 6 clocks -> frame_done=1 for exactly one cycle, digits=32'h87654321, digit_valid=0 afterwards.
REQ-034 Anode 8'b11110011 held 4 clocks -> anode_err=1, digits unchanged; clear_err for one cycle -> anode_err=0.
REQ-035 Anode 8'b11111101 with pattern 1111111 held 4 clocks -> pattern_err=1, digit_valid[1]=0.
REQ-036 Pattern that toggles every 2 clocks for 20 clocks -> no capture, and both error flags stay 0.
REQ-037 rst pulsed low during cycle 2 of a SETTLE window -> all outputs 0 immediately; capture happens only after 4 stable clocks following release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan decoder.
// Holds the FSM states, the active-low hex glyph table and the blank-anode code.
package seg7_pkg;

  localparam int unsigned ANODE_W  = 8;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned DIGITS_W = ANODE_W * NIBBLE_W;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned GLYPHS   = 16;

  localparam logic [ANODE_W-1:0] BLANK_ANODE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_e;

  // One sampled bus beat: scanned anode vector plus the segment pattern.
  typedef struct packed {
    logic [ANODE_W-1:0] anode;
    logic [SEG_W-1:0]   seg;
  } scan_pair_t;

  // Active-low segments, bit6=a .. bit0=g, indexed by hex value.
  localparam logic [SEG_W-1:0] GLYPH_TABLE [GLYPHS] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Number of digit enables driven low in an anode vector.
  function automatic logic [3:0] low_count(input logic [ANODE_W-1:0] anode);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < int'(ANODE_W); i++) begin
      n = n + 4'(!anode[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational lookup of a 7-bit active-low segment pattern into its hex value.
// hit_c_o is low when the pattern matches no entry of the glyph table.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0]    pattern_i,
  output logic [NIBBLE_W-1:0] value_c_o,
  output logic                hit_c_o
);

  always_comb begin
    value_c_o = '0;
    hit_c_o   = 1'b0;
    for (int i = 0; i < int'(GLYPHS); i++) begin
      if (pattern_i == GLYPH_TABLE[i]) begin
        value_c_o = NIBBLE_W'(i);
        hit_c_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers the eight hex digits from a multiplexed, active-low 7-segment scan bus.
// A pair is captured once it has been stable for STABLE_CYCLES sampled clocks.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ANODE_W-1:0]  Anode_Activate,
  input  logic [SEG_W-1:0]    LED_out,
  input  logic                clear_err,
  output logic [DIGITS_W-1:0] digits,
  output logic [ANODE_W-1:0]  digit_valid,
  output logic                frame_done,
  output logic                pattern_err,
  output logic                anode_err
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  scan_pair_t            sample_q, prev_q;
  logic                  eval_c;

  logic [DIGITS_W-1:0]   digits_q, digits_d;
  logic [ANODE_W-1:0]    valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  perr_q, perr_d;
  logic                  aerr_q, aerr_d;

  logic [NIBBLE_W-1:0]   glyph_val_c;
  logic                  glyph_hit_c;
  logic                  blank_c;
  logic                  same_c;
  logic [CNT_W-1:0]      cnt_inc_c;
  logic [ANODE_W-1:0]    sel_c;
  logic [3:0]            lows_c;

  seg7_glyph_decode u_glyph (
    .pattern_i (sample_q.seg),
    .value_c_o (glyph_val_c),
    .hit_c_o   (glyph_hit_c)
  );

  // Input sample register and the copy of last cycle's sample used for stability.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_q <= '1;
      prev_q   <= '1;
    end else begin
      sample_q <= scan_pair_t'({Anode_Activate, LED_out});
      prev_q   <= sample_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign blank_c   = (sample_q.anode == BLANK_ANODE);
  assign same_c    = (sample_q == prev_q);
  assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eval_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!blank_c) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(1);
        end
      end
      SETTLE: begin
        if (same_c) begin
          cnt_d = cnt_inc_c;
        end else if (blank_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = CNT_W'(1);
        end
      end
      HELD: begin
        if (!same_c) begin
          if (blank_c) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = SETTLE;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // The window closes on the edge the count reaches its target, including a restart at 1.
    if (state_d == SETTLE && cnt_d == CNT_TARGET) begin
      eval_c  = 1'b1;
      state_d = HELD;
    end
  end

  assign sel_c  = ~sample_q.anode;
  assign lows_c = low_count(sample_q.anode);

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    perr_d   = clear_err ? 1'b0 : perr_q;
    aerr_d   = clear_err ? 1'b0 : aerr_q;
    if (eval_c) begin
      if (lows_c > 4'd1) begin
        aerr_d = 1'b1;
      end else if (!glyph_hit_c) begin
        perr_d = 1'b1;
      end else begin
        for (int i = 0; i < int'(ANODE_W); i++) begin
          if (sel_c[i]) begin
            digits_d[i*NIBBLE_W +: NIBBLE_W] = glyph_val_c;
          end
        end
        // Completing the mask closes the frame and starts a fresh one.
        if ((valid_q | sel_c) == '1) begin
          done_d  = 1'b1;
          valid_d = '0;
        end else begin
          valid_d = valid_q | sel_c;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits_q <= '0;
      valid_q  <= '0;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      digits_q <= digits_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      perr_q   <= perr_d;
      aerr_q   <= aerr_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign frame_done  = done_q;
  assign pattern_err = perr_q;
  assign anode_err   = aerr_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: run-length reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_seg7_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  Anode_Activate = 8'hFF;
  logic [6:0]  LED_out = 7'h7F;
  logic        clear_err = 1'b0;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        pattern_err;
  logic        anode_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] GLYPHS [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference state: outputs plus the run length of identical non-blank pairs.
  logic [31:0] m_digits = '0;
  logic [7:0]  m_valid = '0;
  logic        m_done = 1'b0;
  logic        m_perr = 1'b0;
  logic        m_aerr = 1'b0;
  int          run = 0;
  logic [7:0]  last_an = 8'hFF;
  logic [6:0]  last_led = 7'h7F;

  seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk            (clk),
    .rst            (rst),
    .Anode_Activate (Anode_Activate),
    .LED_out        (LED_out),
    .clear_err      (clear_err),
    .digits         (digits),
    .digit_valid    (digit_valid),
    .frame_done     (frame_done),
    .pattern_err    (pattern_err),
    .anode_err      (anode_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A pair that was present at exactly S consecutive edges is evaluated on the next edge.
  always @(posedge clk or negedge rst) begin : model
    logic [31:0] nd;
    logic [7:0]  nv;
    logic        nf, np, na, hit;
    logic [3:0]  val;
    int          lows, idx;
    if (!rst) begin
      m_digits <= '0;
      m_valid  <= '0;
      m_done   <= 1'b0;
      m_perr   <= 1'b0;
      m_aerr   <= 1'b0;
      run      <= 0;
      last_an  <= 8'hFF;
      last_led <= 7'h7F;
    end else begin
      nd = m_digits;
      nv = m_valid;
      nf = 1'b0;
      np = clear_err ? 1'b0 : m_perr;
      na = clear_err ? 1'b0 : m_aerr;
      if (run == S) begin
        lows = 0;
        idx  = 0;
        for (int i = 0; i < 8; i++) begin
          if (!last_an[i]) begin
            lows++;
            idx = i;
          end
        end
        if (lows > 1) begin
          na = 1'b1;
        end else begin
          hit = 1'b0;
          val = 4'h0;
          for (int g = 0; g < 16; g++) begin
            if (GLYPHS[g] == last_led) begin
              hit = 1'b1;
              val = 4'(g);
            end
          end
          if (!hit) begin
            np = 1'b1;
          end else begin
            nd[4*idx +: 4] = val;
            if ((nv | (8'd1 << idx)) == 8'hFF) begin
              nf = 1'b1;
              nv = 8'h00;
            end else begin
              nv = nv | (8'd1 << idx);
            end
          end
        end
      end
      if (Anode_Activate == 8'hFF) run <= 0;
      else if (Anode_Activate == last_an && LED_out == last_led) run <= (run < 1000) ? run + 1 : run;
      else run <= 1;
      last_an  <= Anode_Activate;
      last_led <= LED_out;
      m_digits <= nd;
      m_valid  <= nv;
      m_done   <= nf;
      m_perr   <= np;
      m_aerr   <= na;
    end
  end

  always @(negedge clk) begin
    check("model_digits", digits, m_digits);
    check("model_valid", 32'(digit_valid), 32'(m_valid));
    check("model_frame_done", 32'(frame_done), 32'(m_done));
    check("model_pattern_err", 32'(pattern_err), 32'(m_perr));
    check("model_anode_err", 32'(anode_err), 32'(m_aerr));
  end

  task automatic drive(input logic [7:0] an, input logic [6:0] led);
    Anode_Activate = an;
    LED_out        = led;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_digits", digits, 32'h0);
    check("reset_valid", 32'(digit_valid), 32'h0);
    check("reset_flags", {29'd0, frame_done, pattern_err, anode_err}, 32'h0);
    #2 rst = 1'b1;

    // Single digit 3 on digit 0: unchanged at k+3, captured at k+4.
    @(negedge clk);
    drive(8'b11111110, 7'b0000110);
    repeat (4) @(negedge clk);
    check("d0_before_window", 32'(digit_valid), 32'h0);
    @(negedge clk);
    check("d0_digits", digits, 32'h0000_0003);
    check("d0_valid", 32'(digit_valid), 32'h01);
    repeat (3) @(negedge clk);
    check("d0_held_valid", 32'(digit_valid), 32'h01);

    // Full frame of values 1..8, digit 0 overwritten.
    for (int d = 0; d < 8; d++) begin
      drive(8'hFF ^ (8'd1 << d), GLYPHS[d+1]);
      if (d < 7) repeat (6) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("frame_pre_done", 32'(frame_done), 32'h0);
    check("frame_pre_valid", 32'(digit_valid), 32'h7F);
    @(negedge clk);
    check("frame_done_pulse", 32'(frame_done), 32'h1);
    check("frame_digits", digits, 32'h8765_4321);
    check("frame_valid_cleared", 32'(digit_valid), 32'h0);
    @(negedge clk);
    check("frame_done_drop", 32'(frame_done), 32'h0);
    drive(8'hFF, 7'h7F);
    @(negedge clk);

    // Two anodes low.
    drive(8'b11110011, GLYPHS[0]);
    repeat (5) @(negedge clk);
    check("aerr_set", 32'(anode_err), 32'h1);
    check("aerr_digits", digits, 32'h8765_4321);
    drive(8'hFF, 7'h7F);
    pulse_clear();
    check("aerr_cleared", 32'(anode_err), 32'h0);

    // Error and clear on the same edge: the error wins.
    drive(8'b11110011, GLYPHS[0]);
    repeat (4) @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("aerr_beats_clear", 32'(anode_err), 32'h1);
    drive(8'hFF, 7'h7F);
    pulse_clear();

    // Unknown glyph on digit 1.
    drive(8'b11111101, 7'b1111111);
    repeat (5) @(negedge clk);
    check("perr_set", 32'(pattern_err), 32'h1);
    check("perr_no_valid", 32'(digit_valid[1]), 32'h0);
    drive(8'hFF, 7'h7F);
    pulse_clear();
    check("perr_cleared", 32'(pattern_err), 32'h0);

    // Pattern toggling every two clocks never settles.
    for (int t = 0; t < 10; t++) begin
      drive(8'b11111011, (t % 2 == 1) ? GLYPHS[1] : GLYPHS[0]);
      repeat (2) @(negedge clk);
    end
    drive(8'hFF, 7'h7F);
    repeat (2) @(negedge clk);
    check("toggle_valid", 32'(digit_valid), 32'h0);
    check("toggle_flags", {30'd0, pattern_err, anode_err}, 32'h0);
    check("toggle_digits", digits, 32'h8765_4321);

    // Reset in the middle of a settle window.
    drive(8'b11111110, GLYPHS[5]);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_digits", digits, 32'h0);
    check("midrst_outs", {21'd0, digit_valid, frame_done, pattern_err, anode_err}, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_early", 32'(digit_valid), 32'h0);
    @(negedge clk);
    check("midrst_capture_valid", 32'(digit_valid), 32'h01);
    check("midrst_capture_digits", digits, 32'h0000_0005);
    drive(8'hFF, 7'h7F);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
